// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU writes to BASE_ADDR are queued in a
// small FIFO and sent 8N1 LSB-first on tx; status is read at BASE_ADDR+1.
// Build option: define MMIO_UART_TX_PARITY_EN for 8E1 frames (even parity bit).
// Ports:
//   clk    - CPU clock, all state on rising edge
//   rst    - asynchronous active-high reset
//   addr   - CPU address bus
//   di     - CPU write data
//   we     - CPU write strobe
//   dout   - registered status read data {4'b0, ovf, empty, full, busy}
//            (the CPU-side "do" bus; renamed since "do" is a keyword)
//   rd_sel - high when dout carries status (selects it over RAM data)
//   tx     - serial output, idle high
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  di,
    input  logic        we,
    output logic [7:0]  dout,
    output logic        rd_sel,
    output logic        tx
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [15:0]      STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [PW:0]      FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             ovf;

    logic [7:0]       shift_q;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] clk_cnt;
`ifdef MMIO_UART_TX_PARITY_EN
    logic             par_q;
`endif

    logic       push_req;
    logic       push_ok;
    logic       ovf_set;
    logic       stat_rd;
    logic       pop;
    logic       empty;
    logic       full;
    logic       busy;
    logic       bit_end;
    logic [7:0] status;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign busy     = (state_q != IDLE);
    assign push_req = we && (addr == BASE_ADDR);
    assign stat_rd  = !we && (addr == STAT_ADDR);
    assign pop      = (state_q == IDLE) && !empty;
    // A full FIFO still takes the byte when the FSM drains one that edge.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && !push_ok;
    assign bit_end  = (clk_cnt == CNT_LAST);
    assign status   = {4'b0, ovf, empty, full, busy};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= di;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            dout   <= '0;
            rd_sel <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
            // Set wins over read-clear; they cannot coincide anyway.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (stat_rd) begin
                ovf <= 1'b0;
            end
            rd_sel <= stat_rd;
            dout   <= stat_rd ? status : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_idx <= '0;
            clk_cnt <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_d != state_q || bit_end) begin
                clk_cnt <= '0;
            end else if (state_q != IDLE) begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (pop) begin
                shift_q <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
                par_q   <= ^mem[rd_ptr];
`endif
            end else if (state_q == DATA && bit_end) begin
                shift_q <= shift_q >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // tx is decoded from registered state so reset forces it high at once.
    always_comb begin
        state_d = state_q;
        tx      = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end && bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                tx = par_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random bursts
// compared against a frame-level reference model (CLKS_PER_BIT=4, depth 4).
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [15:0] STAT  = 16'hFF01;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  di = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  dout;
    logic        rd_sel;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [10:0] frames_q [$];
    int          starts_q [$];
    logic        rst_seen = 1'b0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .di    (di),
        .we    (we),
        .dout  (dout),
        .rd_sel(rd_sel),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge rst) rst_seen = 1'b1;

    // Line monitor: finds a start bit and samples every bit period.
    initial begin : monitor
        logic [10:0] fr;
        int          t0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                t0       = cyc;
                fr       = '1;
                rst_seen = 1'b0;
                @(negedge clk);
                for (int k = 0; k < NB; k++) begin
                    if (k > 0) repeat (CPB) @(negedge clk);
                    fr[k] = tx;
                end
                if (!rst_seen) begin
                    frames_q.push_back(fr);
                    starts_q.push_back(t0);
                end
            end
        end
    end

    // Reference frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef MMIO_UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic push(input logic [7:0] b);
        addr = BASE;
        di   = b;
        we   = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_bus();
        addr = 16'h0000;
        di   = 8'h00;
        we   = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] s, output logic sel);
        addr = STAT;
        we   = 1'b0;
        @(negedge clk);
        s    = dout;
        sel  = rd_sel;
        idle_bus();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int b;
        b = budget;
        while (frames_q.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        logic       sel;
        rst = 1'b1;
        idle_bus();
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got=%b exp=1", tx);
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_do got=%h exp=00", dout);
        end
        checks++;
        if (rd_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_sel got=%b exp=0", rd_sel);
        end
        rst = 1'b0;
        @(negedge clk);
        read_status(s, sel);
        checks++;
        if (s !== 8'h04 || sel !== 1'b1) begin
            errors++;
            $display("FAIL reset_status got=%h/%b exp=04/1", s, sel);
        end
        addr = 16'h1234;
        @(negedge clk);
        checks++;
        if (rd_sel !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL other_addr got=%h/%b exp=00/0", dout, rd_sel);
        end
        addr = STAT;
        di   = 8'h5A;
        we   = 1'b1;
        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        read_status(s, sel);
        checks++;
        if (s !== 8'h04 || tx !== 1'b1) begin
            errors++;
            $display("FAIL stat_write_ignored got=%h/%b exp=04/1", s, tx);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0]  s;
        logic        sel;
        logic [10:0] fr;
        frames_q.delete();
        starts_q.delete();
        push(8'hA5);
        idle_bus();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL single_early got=%b exp=1", tx);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL single_start got=%b exp=0", tx);
        end
        read_status(s, sel);
        checks++;
        if (s !== 8'h05) begin
            errors++;
            $display("FAIL single_status got=%h exp=05", s);
        end
        wait_frames(1, 60);
        checks++;
        if (frames_q.size() != 1) begin
            errors++;
            $display("FAIL single_count got=%0d exp=1", frames_q.size());
        end else begin
            fr = frames_q[0];
            checks++;
            if (fr !== make_frame(8'hA5)) begin
                errors++;
                $display("FAIL single_frame got=%b exp=%b",
                         fr, make_frame(8'hA5));
            end
`ifndef MMIO_UART_TX_PARITY_EN
            checks++;
            if (fr[9:0] !== 10'b11_0100_1010) begin
                errors++;
                $display("FAIL single_stream got=%b exp=1101001010",
                         fr[9:0]);
            end
`endif
        end
        repeat (CPB + 2) @(negedge clk);
        read_status(s, sel);
        checks++;
        if (s !== 8'h04) begin
            errors++;
            $display("FAIL single_done got=%h exp=04", s);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s;
        logic       sel;
        frames_q.delete();
        starts_q.delete();
        for (int i = 1; i <= 6; i++) push(8'(i));
        read_status(s, sel);
        checks++;
        if (s !== 8'h0B) begin
            errors++;
            $display("FAIL ovf_status got=%h exp=0B", s);
        end
        read_status(s, sel);
        checks++;
        if (s !== 8'h03) begin
            errors++;
            $display("FAIL ovf_cleared got=%h exp=03", s);
        end
        wait_frames(5, 5 * (NB * CPB + 1) + 40);
        checks++;
        if (frames_q.size() != 5) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=5", frames_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (frames_q[i] !== make_frame(8'(i + 1))) begin
                    errors++;
                    $display("FAIL ovf_frame idx=%0d got=%b exp=%b", i,
                             frames_q[i], make_frame(8'(i + 1)));
                end
            end
        end
        repeat (CPB + 2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        frames_q.delete();
        starts_q.delete();
        push(8'h00);
        push(8'hFF);
        idle_bus();
        wait_frames(2, 2 * (NB * CPB + 1) + 40);
        checks++;
        if (frames_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=2", frames_q.size());
        end else begin
            checks++;
            if (starts_q[1] - starts_q[0] != NB * CPB + 1) begin
                errors++;
                $display("FAIL b2b_spacing got=%0d exp=%0d",
                         starts_q[1] - starts_q[0], NB * CPB + 1);
            end
            checks++;
            if (frames_q[0][8:1] !== 8'h00 || frames_q[1][8:1] !== 8'hFF) begin
                errors++;
                $display("FAIL b2b_data got=%h,%h exp=00,ff",
                         frames_q[0][8:1], frames_q[1][8:1]);
            end
            checks++;
            if (frames_q[0] !== make_frame(8'h00)
                || frames_q[1] !== make_frame(8'hFF)) begin
                errors++;
                $display("FAIL b2b_frames got=%b,%b", frames_q[0], frames_q[1]);
            end
        end
        repeat (CPB + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic [7:0] s;
        logic       sel;
        int         bad;
        frames_q.delete();
        starts_q.delete();
        b = 8'($urandom);
        push(b);
        push(8'($urandom));
        idle_bus();
        repeat (4 * CPB) @(negedge clk);
        checks++;
        if (tx !== b[3]) begin
            errors++;
            $display("FAIL mid_bit3 got=%b exp=%b", tx, b[3]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_tx got=%b exp=1", tx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_status(s, sel);
        checks++;
        if (s !== 8'h04) begin
            errors++;
            $display("FAIL mid_status got=%h exp=04", s);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || frames_q.size() != 0) begin
            errors++;
            $display("FAIL mid_quiet low_cycles=%0d frames=%0d exp=0,0",
                     bad, frames_q.size());
        end
    endtask

    task automatic test_random_bursts();
        logic [7:0] s;
        logic       sel;
        logic [7:0] sent [$];
        int         n;
        int         acc;
        for (int it = 0; it < 6; it++) begin
            frames_q.delete();
            starts_q.delete();
            sent.delete();
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) begin
                sent.push_back(8'($urandom));
                push(sent[i]);
            end
            read_status(s, sel);
            // From idle, one byte leaves for the shifter right away.
            acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
            checks++;
            if (s[3] !== (n > DEPTH + 1)) begin
                errors++;
                $display("FAIL rand_ovf it=%0d n=%0d got=%b exp=%b",
                         it, n, s[3], (n > DEPTH + 1));
            end
            wait_frames(acc, acc * (NB * CPB + 1) + 40);
            checks++;
            if (frames_q.size() != acc) begin
                errors++;
                $display("FAIL rand_count it=%0d got=%0d exp=%0d",
                         it, frames_q.size(), acc);
            end else begin
                for (int i = 0; i < acc; i++) begin
                    checks++;
                    if (frames_q[i] !== make_frame(sent[i])) begin
                        errors++;
                        $display("FAIL rand_frame it=%0d idx=%0d got=%b exp=%b",
                                 it, i, frames_q[i], make_frame(sent[i]));
                    end
                end
            end
            repeat (CPB + 2 + $urandom_range(0, 3)) @(negedge clk);
        end
    endtask

`ifdef MMIO_UART_TX_PARITY_EN
    task automatic test_parity();
        frames_q.delete();
        starts_q.delete();
        push(8'h03);
        push(8'h07);
        idle_bus();
        wait_frames(2, 2 * (NB * CPB + 1) + 40);
        checks++;
        if (frames_q.size() != 2) begin
            errors++;
            $display("FAIL par_count got=%0d exp=2", frames_q.size());
        end else begin
            checks++;
            if (frames_q[0][9] !== 1'b0 || frames_q[1][9] !== 1'b1) begin
                errors++;
                $display("FAIL par_bits got=%b,%b exp=0,1",
                         frames_q[0][9], frames_q[1][9]);
            end
            checks++;
            if (starts_q[1] - starts_q[0] != 11 * CPB + 1) begin
                errors++;
                $display("FAIL par_spacing got=%0d exp=%0d",
                         starts_q[1] - starts_q[0], 11 * CPB + 1);
            end
        end
        repeat (CPB + 2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_bursts();
`ifdef MMIO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data bus, alongside the RAM. It decodes CPU writes to its data address, buffers bytes in a small FIFO, and serialises them 8N1 LSB-first on `tx`. A status register reports FIFO and overflow state, so programs such as the Fibonacci test can stream results off-chip instead of being probed through RAM contents.

## Interface
- `BASE_ADDR`, 16'hFF00: data register address; status register is `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, 2..16.

- `clk`  in  1  CPU clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  16  CPU address bus.
- `di`  in  8  CPU write data (CPU `do`).
- `we`  in  1  CPU write strobe.
- `do`  out  8  status read data, registered.
- `rd_sel`  out  1  high when `do` carries status; top level muxes `do` over RAM data into CPU `di`.
- `tx`  out  1  serial output, idle high.

## Operation
- **Push:** `we=1` and `addr==BASE_ADDR` at a clock edge. If the FIFO is not full, `di` is written. If it is full, the byte is dropped and sticky `ovf` is set.
- **Push while full with same-cycle pop:** accepted; count unchanged.
- **Status read:** `addr==BASE_ADDR+1` with `we=0`. Next cycle, `rd_sel=1` and `do={4'b0, ovf, empty, full, busy}`. The same edge that captures `do` clears `ovf`, unless an overflowing push occurs in that same cycle, in which case `ovf` stays set.
- **Writes to `BASE_ADDR+1`:** ignored.
- **Other addresses:** no effect; `rd_sel=0`, `do=0`.
- **Status bits:**
  - `busy`: transmitter not in IDLE.
  - `empty`: count==0.
  - `full`: count==FIFO_DEPTH.
- **FIFO:** pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.
- **Transmit FSM:**
  - IDLE: `tx=1`. If FIFO not empty, pop into shift register and go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx=shift[0]`. Shift right every CLKS_PER_BIT cycles. Go to PARITY or STOP after 8 bits.
  - PARITY (macro only): `tx` = even parity of the byte, CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles, then go to IDLE.
- **Counters:** the bit-period counter counts 0..CLKS_PER_BIT-1 and resets on every state change. The bit index counts 0..7.
- **Back-to-back bytes:** IDLE lasts exactly one cycle between frames, so the frame spacing is (10×CLKS_PER_BIT)+1 cycles without parity.

## Timing
- **Reset values:** `tx=1`, `do=0`, `rd_sel=0`. FSM=IDLE, FIFO empty, `ovf=0`, counters 0.
- **Reset mid-frame:** `tx` goes high immediately (asynchronous) and FIFO contents are discarded.
- **Push to start bit:** push at edge N makes `empty=0` after N. The FSM pops at N+1, and `tx` falls after edge N+1. Latency is 2 edges when idle.
- **Status read latency:** 1 cycle, matching synchronous RAM read timing.
- **Status snapshot:** reflects state after the capture edge's previous values; a push and a status read cannot coincide since they use different addresses.
- **Frame length:** 10×CLKS_PER_BIT cycles, or 11× with parity.

## Configuration
- `MMIO_UART_TX_PARITY_EN`
  - **Defined:** the PARITY state is included and frames are 8E1, 11 bits.
  - **Undefined:** the PARITY state and its logic are absent and frames are 8N1, 10 bits.
  - The status register layout is identical in both cases.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- **Reset:** assert `rst` for 2 cycles → `tx=1`, `do=0`, `rd_sel=0`. A status read afterwards returns 8'h04.
- **Single byte:** write 8'hA5 to FF00 → `tx` falls 2 edges later. Bit-sampled stream over 40 cycles is 0,1,0,1,0,0,1,0,1,1. Status during the frame is 8'h05 (`busy`, `empty`).
- **FIFO fill and overflow:** write 8'h01..8'h06 on consecutive cycles → the first byte is popped at once, so 01..05 are accepted and 06 is dropped. Status returns 8'h0B (`ovf`, `full`, `busy`), and the next status read returns 8'h03.
- **Back-to-back frames:** queue 8'h00 and 8'hFF → the second start bit falls 41 cycles after the first; `tx` shows 8 zeros, then 8 ones, with no gap beyond one idle cycle.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → `tx=1` the same cycle. After release, status is 8'h04 and no further frame is sent.
- **Parity (macro defined):** send 8'h03 → parity bit 0, 44-cycle frame. Send 8'h07 → parity bit 1.
